// File: rtl/onchip_mem_arbiter_if.sv
// Bus bundle for onchip_mem_arbiter: two requester ports, clock-enable hold and the shared memory port.
// slave = arbiter view, master = requester/memory environment view.
interface onchip_mem_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
);
  logic                  reset_req;

  logic [ADDR_W-1:0]     m0_address;
  logic [DATA_W/8-1:0]   m0_byteenable;
  logic                  m0_read;
  logic                  m0_write;
  logic [DATA_W-1:0]     m0_writedata;
  logic                  m0_lock;
  logic                  m0_waitrequest;
  logic [DATA_W-1:0]     m0_readdata;
  logic                  m0_readdatavalid;

  logic [ADDR_W-1:0]     m1_address;
  logic [DATA_W/8-1:0]   m1_byteenable;
  logic                  m1_read;
  logic                  m1_write;
  logic [DATA_W-1:0]     m1_writedata;
  logic                  m1_lock;
  logic                  m1_waitrequest;
  logic [DATA_W-1:0]     m1_readdata;
  logic                  m1_readdatavalid;

  logic [ADDR_W-1:0]     mem_address;
  logic [DATA_W/8-1:0]   mem_byteenable;
  logic [DATA_W-1:0]     mem_writedata;
  logic                  mem_chipselect;
  logic                  mem_write;
  logic                  mem_clken;
  logic [DATA_W-1:0]     mem_readdata;

  modport slave (
    input  reset_req,
    input  m0_address, m0_byteenable, m0_read, m0_write, m0_writedata, m0_lock,
    output m0_waitrequest, m0_readdata, m0_readdatavalid,
    input  m1_address, m1_byteenable, m1_read, m1_write, m1_writedata, m1_lock,
    output m1_waitrequest, m1_readdata, m1_readdatavalid,
    output mem_address, mem_byteenable, mem_writedata, mem_chipselect, mem_write, mem_clken,
    input  mem_readdata
  );

  modport master (
    output reset_req,
    output m0_address, m0_byteenable, m0_read, m0_write, m0_writedata, m0_lock,
    input  m0_waitrequest, m0_readdata, m0_readdatavalid,
    output m1_address, m1_byteenable, m1_read, m1_write, m1_writedata, m1_lock,
    input  m1_waitrequest, m1_readdata, m1_readdatavalid,
    input  mem_address, mem_byteenable, mem_writedata, mem_chipselect, mem_write, mem_clken,
    output mem_readdata
  );
endinterface

// File: rtl/onchip_mem_arbiter.sv
// Two-port arbiter onto a single on-chip memory port with lock and bounded hold (MAX_HOLD).
// Define ONCHIP_MEM_ARB_ROUND_ROBIN_EN for round-robin contention; default is port-0 fixed priority.
module onchip_mem_arbiter #(
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 8
) (
  input logic                 clk,
  input logic                 reset_n,
  onchip_mem_arbiter_if.slave bus
);
  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t     r_state;
  logic [7:0] r_cnt;
  logic       r_yield_v;
  logic       r_yield_port;
  logic       r_rdv0;
  logic       r_rdv1;
`ifdef ONCHIP_MEM_ARB_ROUND_ROBIN_EN
  logic       r_ptr;
`endif

  logic w_req0, w_req1, w_go, w_pref;
  logic w_gnt0, w_gnt1, w_acc0, w_acc1;
  logic w_own1, w_own_acc, w_own_lock, w_oth_req, w_hit;
  logic w_idle_lock, w_idle_oth;
  logic [7:0]          w_cnt_inc;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W/8-1:0] w_be;
  logic [DATA_W-1:0]   w_wdata;

  assign w_req0 = bus.m0_read | bus.m0_write;
  assign w_req1 = bus.m1_read | bus.m1_write;
  assign w_go   = reset_n & ~bus.reset_req;

  // A pending yield (set when an owner leaves while the other port waits) overrides normal priority once.
`ifdef ONCHIP_MEM_ARB_ROUND_ROBIN_EN
  assign w_pref = r_yield_v ? r_yield_port : r_ptr;
`else
  assign w_pref = r_yield_v & r_yield_port;
`endif

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    case (r_state)
      OWN0:    w_gnt0 = 1'b1;
      OWN1:    w_gnt1 = 1'b1;
      default: begin
        if (w_req0 && w_req1) begin
          w_gnt0 = ~w_pref;
          w_gnt1 = w_pref;
        end else begin
          w_gnt0 = w_req0;
          w_gnt1 = w_req1;
        end
      end
    endcase
  end

  assign w_acc0 = w_req0 & w_gnt0 & w_go;
  assign w_acc1 = w_req1 & w_gnt1 & w_go;

  assign bus.m0_waitrequest = w_req0 & ~w_acc0;
  assign bus.m1_waitrequest = w_req1 & ~w_acc1;

  always_comb begin
    w_addr  = '0;
    w_be    = '0;
    w_wdata = '0;
    if (w_acc0) begin
      w_addr  = bus.m0_address;
      w_be    = bus.m0_byteenable;
      w_wdata = bus.m0_writedata;
    end else if (w_acc1) begin
      w_addr  = bus.m1_address;
      w_be    = bus.m1_byteenable;
      w_wdata = bus.m1_writedata;
    end
  end

  assign bus.mem_address    = w_addr;
  assign bus.mem_byteenable = w_be;
  assign bus.mem_writedata  = w_wdata;
  assign bus.mem_chipselect = w_acc0 | w_acc1;
  assign bus.mem_write      = (w_acc0 & bus.m0_write) | (w_acc1 & bus.m1_write);
  assign bus.mem_clken      = ~bus.reset_req;

  assign bus.m0_readdatavalid = r_rdv0;
  assign bus.m1_readdatavalid = r_rdv1;
  assign bus.m0_readdata      = r_rdv0 ? bus.mem_readdata : '0;
  assign bus.m1_readdata      = r_rdv1 ? bus.mem_readdata : '0;

  assign w_own1     = (r_state == OWN1);
  assign w_own_acc  = w_own1 ? w_acc1 : w_acc0;
  assign w_own_lock = w_own1 ? bus.m1_lock : bus.m0_lock;
  assign w_oth_req  = w_own1 ? w_req0 : w_req1;
  assign w_cnt_inc  = (r_cnt >= HOLD_MAX) ? r_cnt : r_cnt + 8'd1;
  assign w_hit      = w_own_acc & w_oth_req & (w_cnt_inc >= HOLD_MAX);

  assign w_idle_lock = (w_acc0 & bus.m0_lock) | (w_acc1 & bus.m1_lock);
  assign w_idle_oth  = w_acc1 ? w_req0 : w_req1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_yield_v    <= 1'b0;
      r_yield_port <= 1'b0;
      r_rdv0       <= 1'b0;
      r_rdv1       <= 1'b0;
`ifdef ONCHIP_MEM_ARB_ROUND_ROBIN_EN
      r_ptr        <= 1'b0;
`endif
    end else begin
      r_rdv0 <= w_acc0 & ~bus.m0_write;
      r_rdv1 <= w_acc1 & ~bus.m1_write;
      if (w_go) begin
`ifdef ONCHIP_MEM_ARB_ROUND_ROBIN_EN
        if (w_acc0)      r_ptr <= 1'b1;
        else if (w_acc1) r_ptr <= 1'b0;
`endif
        case (r_state)
          IDLE: begin
            r_yield_v <= 1'b0;
            if (w_idle_lock) begin
              // The entering transfer already counts toward the hold limit.
              if (w_idle_oth && HOLD_MAX == 8'd1) begin
                r_yield_v    <= 1'b1;
                r_yield_port <= ~w_acc1;
              end else begin
                r_state <= w_acc1 ? OWN1 : OWN0;
                r_cnt   <= {7'd0, w_idle_oth};
              end
            end
          end
          default: begin
            if (w_own_acc && w_oth_req) r_cnt <= w_cnt_inc;
            if (!w_own_lock || w_hit) begin
              r_state      <= IDLE;
              r_yield_v    <= w_oth_req;
              r_yield_port <= ~w_own1;
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed self-checking bench for onchip_mem_arbiter with a byte-enabled, latency-1 memory model.
module tb_onchip_mem_arbiter;
  localparam int ADDR_W   = 15;
  localparam int DATA_W   = 32;
  localparam int MAX_HOLD = 8;
`ifdef ONCHIP_MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  onchip_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Memory model: unwritten word at address a reads as 0xA5A5_0000 | a.
  logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] r_rd;
  assign bus.mem_readdata = r_rd;

  always @(posedge clk) begin
    logic [DATA_W-1:0] w;
    if (bus.mem_clken && bus.mem_chipselect) begin
      w = mem.exists(bus.mem_address) ? mem[bus.mem_address]
                                      : (32'hA5A5_0000 | {17'd0, bus.mem_address});
      if (bus.mem_write) begin
        for (int b = 0; b < DATA_W/8; b++)
          if (bus.mem_byteenable[b]) w[b*8 +: 8] = bus.mem_writedata[b*8 +: 8];
        mem[bus.mem_address] = w;
      end else begin
        r_rd <= w;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drv0(input logic rd, input logic wr, input logic lk, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W/8-1:0] be, input logic [DATA_W-1:0] wd);
    bus.m0_read = rd; bus.m0_write = wr; bus.m0_lock = lk;
    bus.m0_address = a; bus.m0_byteenable = be; bus.m0_writedata = wd;
  endtask

  task automatic drv1(input logic rd, input logic wr, input logic lk, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W/8-1:0] be, input logic [DATA_W-1:0] wd);
    bus.m1_read = rd; bus.m1_write = wr; bus.m1_lock = lk;
    bus.m1_address = a; bus.m1_byteenable = be; bus.m1_writedata = wd;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_g1, prev_g1;
    bus.reset_req = 1'b0;
    drv0(0, 0, 0, '0, '0, '0);
    drv1(0, 0, 0, '0, '0, '0);
    #2;
    drv0(1, 0, 0, 15'h10, 4'hF, '0);
    @(negedge clk);
    chk("rst_wait0", bus.m0_waitrequest, 1);
    chk("rst_cs", bus.mem_chipselect, 0);
    chk("rst_wr", bus.mem_write, 0);
    chk("rst_rdv0", bus.m0_readdatavalid, 0);
    chk("rst_rdv1", bus.m1_readdatavalid, 0);
    drv0(0, 0, 0, '0, '0, '0);
    @(negedge clk);
    reset_n = 1'b1;

    // Single read from port 0.
    nxt(); drv0(1, 0, 0, 15'h10, 4'hF, '0);
    @(negedge clk);
    chk("rd_wait0", bus.m0_waitrequest, 0);
    chk("rd_wait1", bus.m1_waitrequest, 0);
    chk("rd_addr", bus.mem_address, 15'h10);
    chk("rd_cs", bus.mem_chipselect, 1);
    chk("rd_wr", bus.mem_write, 0);
    chk("rd_clken", bus.mem_clken, 1);
    nxt(); drv0(0, 0, 0, '0, '0, '0);
    @(negedge clk);
    chk("rd_rdv0", bus.m0_readdatavalid, 1);
    chk("rd_data0", bus.m0_readdata, 32'hA5A5_0010);
    chk("rd_rdv1", bus.m1_readdatavalid, 0);

    // Partial write from port 0, then read of the same word from port 1.
    nxt(); drv0(0, 1, 0, 15'h5, 4'h3, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("wr_wait0", bus.m0_waitrequest, 0);
    chk("wr_memwr", bus.mem_write, 1);
    chk("wr_wdata", bus.mem_writedata, 32'hDEAD_BEEF);
    chk("wr_be", bus.mem_byteenable, 4'h3);
    nxt(); drv0(0, 0, 0, '0, '0, '0); drv1(1, 0, 0, 15'h5, 4'hF, '0);
    @(negedge clk);
    chk("raw_wait1", bus.m1_waitrequest, 0);
    chk("raw_addr", bus.mem_address, 15'h5);
    chk("wr_no_rdv0", bus.m0_readdatavalid, 0);
    nxt(); drv1(0, 0, 0, '0, '0, '0);
    @(negedge clk);
    chk("raw_rdv1", bus.m1_readdatavalid, 1);
    chk("raw_data1", bus.m1_readdata, 32'hA5A5_BEEF);

    // Unlocked contention: alternation (round-robin) or port 0 always (fixed).
    prev_g1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nxt(); drv0(1, 0, 0, 15'h20, 4'hF, '0); drv1(1, 0, 0, 15'h30, 4'hF, '0);
      @(negedge clk);
      exp_g1 = RR && (i % 2 == 1);
      chk("ctn_wait0", bus.m0_waitrequest, exp_g1);
      chk("ctn_wait1", bus.m1_waitrequest, !exp_g1);
      chk("ctn_addr", bus.mem_address, exp_g1 ? 15'h30 : 15'h20);
      if (i > 0) begin
        chk("ctn_rdv0", bus.m0_readdatavalid, !prev_g1);
        chk("ctn_rdv1", bus.m1_readdatavalid, prev_g1);
      end
      prev_g1 = exp_g1;
    end
    nxt(); drv0(0, 0, 0, '0, '0, '0); drv1(0, 0, 0, '0, '0, '0);
    @(negedge clk);
    chk("ctn_last1", bus.m1_readdata, prev_g1 ? 32'hA5A5_0030 : 32'h0);
    chk("ctn_last0", bus.m0_readdata, prev_g1 ? 32'h0 : 32'hA5A5_0020);

    // Locked writes from port 0 with port 1 waiting: 8 transfers, then port 1, then port 0 again.
    for (int i = 0; i < 12; i++) begin
      nxt();
      drv0(0, 1, 1, 15'h100 + 15'(i), 4'hF, 32'(i));
      if (i <= 8) drv1(1, 0, 0, 15'h60, 4'hF, '0);
      else        drv1(0, 0, 0, '0, '0, '0);
      @(negedge clk);
      chk("hold_wait0", bus.m0_waitrequest, i == 8);
      chk("hold_wait1", bus.m1_waitrequest, i < 8);
      chk("hold_rdv1", bus.m1_readdatavalid, i == 9);
      if (i == 9) chk("hold_data1", bus.m1_readdata, 32'hA5A5_0060);
    end
    nxt(); drv0(0, 1, 0, 15'h200, 4'hF, '0);
    @(negedge clk);
    chk("unlock_wait0", bus.m0_waitrequest, 0);

    // Clock-enable hold for 3 cycles while port 0 owns the bus and port 1 waits.
    nxt(); drv0(0, 1, 1, 15'h201, 4'hF, '0);
    @(negedge clk);
    chk("own_wait0", bus.m0_waitrequest, 0);
    nxt(); drv1(1, 0, 0, 15'h70, 4'hF, '0);
    @(negedge clk);
    chk("own2_wait0", bus.m0_waitrequest, 0);
    chk("own2_wait1", bus.m1_waitrequest, 1);
    for (int i = 0; i < 3; i++) begin
      nxt(); bus.reset_req = 1'b1;
      @(negedge clk);
      chk("rq_wait0", bus.m0_waitrequest, 1);
      chk("rq_wait1", bus.m1_waitrequest, 1);
      chk("rq_cs", bus.mem_chipselect, 0);
      chk("rq_clken", bus.mem_clken, 0);
    end
    nxt(); bus.reset_req = 1'b0;
    @(negedge clk);
    chk("resume_wait0", bus.m0_waitrequest, 0);
    chk("resume_wait1", bus.m1_waitrequest, 1);
    nxt(); drv0(0, 0, 0, '0, '0, '0);
    @(negedge clk);
    chk("release_wait1", bus.m1_waitrequest, 1);
    nxt();
    @(negedge clk);
    chk("handoff_wait1", bus.m1_waitrequest, 0);
    nxt(); drv1(0, 0, 0, '0, '0, '0);
    @(negedge clk);
    chk("handoff_data1", bus.m1_readdata, 32'hA5A5_0070);

    // Read data pending when reset_req rises is still delivered.
    nxt(); drv0(1, 0, 0, 15'h10, 4'hF, '0);
    @(negedge clk);
    chk("pend_wait0", bus.m0_waitrequest, 0);
    nxt(); bus.reset_req = 1'b1; drv0(1, 0, 0, 15'h11, 4'hF, '0);
    @(negedge clk);
    chk("pend_rdv0", bus.m0_readdatavalid, 1);
    chk("pend_data0", bus.m0_readdata, 32'hA5A5_0010);
    chk("pend_wait0_rq", bus.m0_waitrequest, 1);
    nxt(); bus.reset_req = 1'b0;
    @(negedge clk);
    chk("pend_rdv0_gap", bus.m0_readdatavalid, 0);
    chk("pend_wait0_go", bus.m0_waitrequest, 0);
    nxt(); drv0(0, 0, 0, '0, '0, '0);
    @(negedge clk);
    chk("pend_data0_b", bus.m0_readdata, 32'hA5A5_0011);

    // Reset right after a port 1 read is accepted discards its read data.
    nxt(); drv1(1, 0, 0, 15'h50, 4'hF, '0);
    @(negedge clk);
    chk("prerst_wait1", bus.m1_waitrequest, 0);
    reset_n = 1'b0;
    nxt();
    @(negedge clk);
    chk("inrst_rdv1", bus.m1_readdatavalid, 0);
    chk("inrst_wait1", bus.m1_waitrequest, 1);
    chk("inrst_cs", bus.mem_chipselect, 0);
    reset_n = 1'b1;
    #1;
    chk("postrst_rdv1", bus.m1_readdatavalid, 0);
    chk("postrst_wait1", bus.m1_waitrequest, 0);
    chk("postrst_addr", bus.mem_address, 15'h50);
    nxt(); drv1(0, 0, 0, '0, '0, '0);
    @(negedge clk);
    chk("postrst_rdv1b", bus.m1_readdatavalid, 1);
    chk("postrst_data1", bus.m1_readdata, 32'hA5A5_0050);

    // After reset, contention favours port 0 in either mode.
    nxt(); drv0(1, 0, 0, 15'h80, 4'hF, '0); drv1(1, 0, 0, 15'h90, 4'hF, '0);
    @(negedge clk);
    chk("rstctn_wait0", bus.m0_waitrequest, 0);
    chk("rstctn_wait1", bus.m1_waitrequest, 1);
    nxt(); drv0(0, 0, 0, '0, '0, '0); drv1(0, 0, 0, '0, '0, '0);
    @(negedge clk);
    chk("rstctn_data0", bus.m0_readdata, 32'hA5A5_0080);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
